scalar_fetch_unit: RTL and testbench

Instruction prefetch stage sitting directly upstream of the scalar datapath, between the datapath and the instruction-cache side of the memory system. Issues sequential word fetches to instruction memory, buffers returned instructions with their PCs in a small FIFO, and presents the oldest one to the datapath with a valid flag. A datapath redirect (branch, jump, JR) flushes the buffer and restarts fetch at the new PC; a halt stops all further fetching.

---
 rtl/cpu_types_pkg.sv | 11 +
 rtl/scalar_fetch_unit_if.sv | 26 ++
 rtl/fetch_fifo.sv | 55 +++++
 rtl/scalar_fetch_unit.sv | 64 ++++++
 tb/tb_scalar_fetch_unit.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared scalar-core types: machine word and the prefetch buffer entry.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t instr;
    word_t pc;
  } fetch_entry_t;

endpackage

// File: rtl/scalar_fetch_unit_if.sv
// Datapath and instruction-memory signals of the fetch unit; master is the fetch unit side.
interface scalar_fetch_unit_if;
  import cpu_types_pkg::*;

  logic  redirect_en;
  word_t redirect_pc;
  logic  consume;
  logic  halt;
  logic  imem_ren;
  word_t imem_addr;
  logic  imem_hit;
  word_t imem_load;
  logic  instr_valid;
  word_t instr;
  word_t instr_pc;

  modport master (
    input  redirect_en, redirect_pc, consume, halt, imem_hit, imem_load,
    output imem_ren, imem_addr, instr_valid, instr, instr_pc
  );

  modport slave (
    output redirect_en, redirect_pc, consume, halt, imem_hit, imem_load,
    input  imem_ren, imem_addr, instr_valid, instr, instr_pc
  );
endinterface

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH-entry FIFO, head visible combinationally, one-cycle push-to-head.
// Flush discards all entries and takes priority over push and pop in the same cycle.
module fetch_fifo
  import cpu_types_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic   CLK,
  input  logic   nRST,
  input  logic   push_i,
  input  entry_t push_dat_i,
  input  logic   pop_i,
  input  logic   flush_i,
  output logic   full_o,
  output logic   empty_o,
  output entry_t head_o
);
  localparam int AW = $clog2(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [AW:0]   rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]   one;

  assign one = {{AW{1'b0}}, 1'b1};

  always_comb begin
    rd_d = rd_q;
    wr_d = wr_q;
    if (flush_i) begin
      rd_d = wr_q;
    end else begin
      if (push_i) wr_d = wr_q + one;
      if (pop_i)  rd_d = rd_q + one;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_q <= '0;
      wr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      if (push_i && !flush_i) mem_q[wr_q[AW-1:0]] <= push_dat_i;
    end
  end

  // Extra pointer MSB separates the wrapped-full case from empty.
  assign empty_o = (rd_q == wr_q);
  assign full_o  = (rd_q[AW] != wr_q[AW]) && (rd_q[AW-1:0] == wr_q[AW-1:0]);
  assign head_o  = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/scalar_fetch_unit.sv
// Sequential instruction prefetch into fetch_fifo; fetched word visible one cycle after its hit.
// Fetch stalls while the buffer is full or after halt; redirect flushes and restarts at the new PC.
module scalar_fetch_unit
  import cpu_types_pkg::*;
#(
  parameter int    DEPTH   = 4,
  parameter word_t PC_INIT = 32'h0
) (
  input logic                 CLK,
  input logic                 nRST,
  scalar_fetch_unit_if.master bus
);
  word_t        fetch_pc_q, fetch_pc_d;
  logic         halted_q, halted_d;
  logic         fifo_full, fifo_empty;
  logic         ren, accept, pop;
  fetch_entry_t push_dat, head;

  assign ren    = !fifo_full && !halted_q;
  assign accept = ren && bus.imem_hit && !bus.redirect_en;
  assign pop    = bus.consume && !fifo_empty && !bus.redirect_en;

  assign push_dat.instr = bus.imem_load;
  assign push_dat.pc    = fetch_pc_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    halted_d   = halted_q | bus.halt;
    if (bus.redirect_en)  fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
    else if (accept)      fetch_pc_d = fetch_pc_q + 32'd4;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetch_pc_q <= PC_INIT;
      halted_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      halted_q   <= halted_d;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .CLK        (CLK),
    .nRST       (nRST),
    .push_i     (accept),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .flush_i    (bus.redirect_en),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_o     (head)
  );

  assign bus.imem_ren    = ren;
  assign bus.imem_addr   = fetch_pc_q;
  assign bus.instr_valid = !fifo_empty;
  assign bus.instr       = head.instr;
  assign bus.instr_pc    = head.pc;

endmodule

// File: tb/tb_scalar_fetch_unit.sv
// Random and directed stimulus against a queue-based reference model of the prefetch buffer.
module tb_scalar_fetch_unit;
  import cpu_types_pkg::*;

  localparam int    DEPTH   = 4;
  localparam word_t PC_INIT = 32'h0;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  bit   chk_en = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 CLK = ~CLK;

  scalar_fetch_unit_if bus ();

  scalar_fetch_unit #(.DEPTH(DEPTH), .PC_INIT(PC_INIT)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  // Reference model: expected buffer contents, fetch address and halt state after the last edge.
  fetch_entry_t exp_q[$];
  word_t        m_pc = PC_INIT;
  bit           m_halted = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ren();
    return (exp_q.size() < DEPTH) && !m_halted;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_pc     = PC_INIT;
    m_halted = 1'b0;
  endtask

  task automatic set_idle();
    bus.redirect_en = 1'b0;
    bus.redirect_pc = '0;
    bus.consume     = 1'b0;
    bus.halt        = 1'b0;
    bus.imem_hit    = 1'b0;
    bus.imem_load   = '0;
  endtask

  // Drives one cycle of inputs and advances the model to the state after the coming edge.
  task automatic cycle(input logic r, input word_t rpc, input logic c, input logic h,
                       input logic hit, input word_t load);
    fetch_entry_t e;
    bit can_fetch;
    bit do_pop;
    @(negedge CLK);
    bus.redirect_en = r;
    bus.redirect_pc = rpc;
    bus.consume     = c;
    bus.halt        = h;
    bus.imem_hit    = hit;
    bus.imem_load   = load;
    can_fetch = m_ren();
    do_pop    = c && (exp_q.size() != 0);
    if (r) begin
      exp_q.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (do_pop) void'(exp_q.pop_front());
      if (can_fetch && hit) begin
        e.instr = load;
        e.pc    = m_pc;
        exp_q.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
    if (h) m_halted = 1'b1;
  endtask

  // Monitor: compares DUT-presented state with the scoreboard after every edge.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (chk_en) begin
        chk("imem_ren", 32'(bus.imem_ren), 32'(m_ren()));
        chk("imem_addr", bus.imem_addr, m_pc);
        chk("instr_valid", 32'(bus.instr_valid), 32'(exp_q.size() != 0));
        if (bus.instr_valid && exp_q.size() != 0) begin
          chk("instr", bus.instr, exp_q[0].instr);
          chk("instr_pc", bus.instr_pc, exp_q[0].pc);
        end
      end
    end
  end

  task automatic after_edge();
    @(posedge CLK);
    #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
    chk({tag, "_instr"}, bus.instr, 32'd0);
    chk({tag, "_pc"}, bus.instr_pc, 32'd0);
    chk({tag, "_addr"}, bus.imem_addr, PC_INIT);
    chk({tag, "_ren"}, 32'(bus.imem_ren), 32'd1);
  endtask

  initial begin
    set_idle();
    #3;
    check_reset_outputs("rst0");
    model_reset();
    @(negedge CLK);
    nRST   = 1'b1;
    chk_en = 1'b1;

    // Streaming: hit and consume every cycle.
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, $urandom);

    // Fill from address 0 without consuming; stall at 16.
    cycle(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, $urandom);
    after_edge();
    chk("full_ren", 32'(bus.imem_ren), 32'd0);
    chk("full_addr", bus.imem_addr, 32'd16);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, $urandom);
    after_edge();
    chk("pop_ren", 32'(bus.imem_ren), 32'd1);
    chk("pop_addr", bus.imem_addr, 32'd16);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, $urandom);
    after_edge();
    chk("refill_addr", bus.imem_addr, 32'd20);

    // Redirect while full with hit and consume asserted.
    cycle(1'b1, 32'h0000_0103, 1'b1, 1'b0, 1'b1, $urandom);
    after_edge();
    chk("redir_addr", bus.imem_addr, 32'h100);
    chk("redir_valid", 32'(bus.instr_valid), 32'd0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, $urandom);
    after_edge();
    chk("redir_first_pc", bus.instr_pc, 32'h100);

    // Push and pop together at occupancy 2.
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, $urandom);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, $urandom);
    after_edge();
    chk("pushpop_head", bus.instr_pc, 32'h104);

    // Address wrap past 2^32.
    cycle(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, $urandom);
    after_edge();
    chk("wrap_addr", bus.imem_addr, 32'd8);

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(15) == 0, $urandom, $urandom_range(1) == 1, 1'b0,
            $urandom_range(3) != 0, $urandom);

    // Halt at occupancy 3, drain, then redirect must not fetch.
    cycle(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, $urandom);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    after_edge();
    chk("halt_ren", 32'(bus.imem_ren), 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, $urandom);
    after_edge();
    chk("halt_drained", 32'(bus.instr_valid), 32'd0);
    cycle(1'b1, 32'h400, 1'b0, 1'b0, 1'b1, $urandom);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, $urandom);
    after_edge();
    chk("halt_redir_addr", bus.imem_addr, 32'h400);
    chk("halt_redir_ren", 32'(bus.imem_ren), 32'd0);
    chk("halt_redir_valid", 32'(bus.instr_valid), 32'd0);

    // Asynchronous reset mid-cycle with no hit.
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    @(posedge CLK);
    #3;
    set_idle();
    nRST = 1'b0;
    #1;
    check_reset_outputs("rst1");
    model_reset();
    @(negedge CLK);
    nRST = 1'b1;

    for (int i = 0; i < 1000; i++)
      cycle($urandom_range(15) == 0, $urandom, $urandom_range(1) == 1, 1'b0,
            $urandom_range(3) != 0, $urandom);
    after_edge();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
